s_axis_cc_adapt_x4: RTL
=======================

Name: s_axis_cc_adapt_x4

Overview:
- Converts LitePCIe legacy-format completion TLPs (3DW PCIe header + payload on a 128-bit stream) into the UltraScale+ completer-completion (CC) AXI-Stream format for the x4 hard block.
- Remaps the header into the 96-bit CC descriptor, converts byte-keep to dword-keep, and checks payload length against the header.
- Drops non-completion packets.
- Sits between the LitePCIe completion source and the core's s_axis_cc port; it is the transmit-side counterpart of the CQ receive adapter.

Parameters:
- DATA_WIDTH, 128, stream data width; only 128 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, byte-keep width on the legacy side.

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  asynchronous, active-high reset.
- s_axis_cc_tdata  in  128  legacy TLP beat; DW0 in bits [31:0].
- s_axis_cc_tkeep  in  16  byte keep.
- s_axis_cc_tlast  in  1  end of packet.
- s_axis_cc_tuser  in  4  bit 0 = error/abort request; bits [3:1] ignored.
- s_axis_cc_tvalid  in  1  beat valid.
- s_axis_cc_tready  out  1  adapter can accept.
- s_axis_cc_tdata_a  out  128  CC beat to core.
- s_axis_cc_tkeep_a  out  4  dword keep.
- s_axis_cc_tlast_a  out  1  end of packet.
- s_axis_cc_tuser_a  out  33  bit 0 = discontinue; bits [32:1] = 0 (parity unused).
- s_axis_cc_tvalid_a  out  1  beat valid.
- s_axis_cc_tready_a  in  4  core ready; only bit 0 is used.
- cpl_drop  out  1  one-cycle pulse when a packet is dropped.

Behaviour:
- Reset (async assert, sync release):
  - s_axis_cc_tvalid_a=0, s_axis_cc_tready=0 while reset is asserted, 1 after release.
  - cpl_drop=0; all other outputs 0; state=HDR; skid and output registers empty; dword counter=0.
- Pipeline:
  - One output register stage plus a one-entry skid buffer.
  - s_axis_cc_tready = !skid_full; it does not depend combinationally on s_axis_cc_tready_a[0].
  - Latency is 1 cycle from input accept to s_axis_cc_tvalid_a.
  - Throughput is 1 beat/cycle when the core is ready.
  - Output holds stable while tvalid_a && !tready_a[0].
- Legacy header fields:
  - DW0: len[9:0], attr[13:12], EP[14], TD[15], TC[22:20], type[28:24], fmt[31:29].
  - DW1: bytecount[11:0], BCM[12], status[15:13], completer_id[31:16].
  - DW2: lower_addr[6:0], tag[15:8], requester_id[31:16].
  - DW3: first payload dword.
- State HDR (first beat of a packet):
  - If type[4:1] != 4'b0101 (not Cpl/CplD/CplLk/CplDLk): go to DROP, or stay in HDR if tlast. Pulse cpl_drop on the header beat.
  - Otherwise emit the descriptor:
    - DW0' = {2'b0, locked, bytecount13, 6'b0, 2'b00 AT, 1'b0, lower_addr}.
    - bytecount13 = (bytecount==0) ? 13'h1000 : {1'b0, bytecount}.
    - locked = (type==5'b01011).
    - DW1' = {requester_id, 1'b0, EP, status, dwcount11}; dwcount11 = (len==0) ? 11'd1024 : len.
    - DW2' = {1'b0 force_ecrc, {1'b0, attr}, TC, 1'b1 completer_id_en, completer_id, tag}.
    - DW3 passes unchanged.
  - Go to BODY if !tlast.
- State BODY: data passes unchanged. Go to HDR on tlast.
- State DROP: consume beats with no output. Go to HDR on tlast.
- tkeep_a:
  - Header beat: 4'b0111 if fmt[1]==0 (no data); otherwise {tkeep[12], 3'b111}.
  - Other beats: {tkeep[12], tkeep[8], tkeep[4], tkeep[0]}.
- Length check (fmt[1]==1):
  - Counter = number of payload dwords sent (the header beat counts tkeep[12]), 11 bits; saturates at 1024, no wrap.
  - At tlast, expected = dwcount11 for data completions, 0 for no-data completions.
  - Mismatch sets tuser_a[0]=1 on the last beat.
- s_axis_cc_tuser[0]=1 on any beat of a packet forces discontinue on that packet's last beat.
- Discontinue never alters tlast or beat count.
- Simultaneous skid drain and new input accept: the skid entry is emitted first; ordering is preserved.
- Single-beat packets (tlast on the header beat) are legal in all states.

Decomposition:
- Package pcie_cc_adapt_pkg holds:
  - legacy header bit-position constants;
  - completion type codes (CPL 5'b01010, CPLLK 5'b01011);
  - CC descriptor field offsets;
  - state encoding HDR/BODY/DROP.
- Sub-module axis_skid_reg (one-entry skid plus output register, parameterised width) carries {tdata, tkeep_a, tlast, tuser_a}.

Test Plan:
1. CplD, len=1, bytecount=4, lower_addr=0x10, tag=0x2A, status=0, single beat, tkeep=16'hFFFF -> one beat out: tkeep_a=4'hF, DW1'[10:0]=1, DW0'[28:16]=4, DW0'[6:0]=0x10, DW2'[7:0]=0x2A, tuser_a[0]=0, 1 cycle latency.
2. CplD, len=8 over 3 beats, core tready_a toggling 1010… -> payload identical and in order; tvalid_a/tdata_a stable while stalled; no beat lost; tuser_a[0]=0.
3. Cpl no data, status=3'b001 (UR), bytecount=0 -> tkeep_a=4'b0111, DW1'[13:11]=1, DW0'[28:16]=13'h1000.
4. CplD, header len=4 but only 3 dwords sent -> last beat tuser_a[0]=1; next back-to-back packet clean.
5. MWr-type packet (type=5'b00000) of 2 beats, then a CplD -> cpl_drop pulses once; only the CplD appears on the output.
6. Reset asserted mid-BODY with tvalid_a=1 -> tvalid_a drops asynchronously; after release, the next packet is parsed as a header.

Source files
------------

// File: rtl/pcie_cc_adapt_pkg.sv
// Shared constants for the legacy-TLP to UltraScale+ CC adapter: legacy header
// bit positions (within the 128-bit header beat), CC descriptor offsets, state encoding.
package pcie_cc_adapt_pkg;

  // Legacy 3DW header, DW0 at [31:0], DW1 at [63:32], DW2 at [95:64]
  localparam int LEN_LSB    = 0;
  localparam int ATTR_LSB   = 12;
  localparam int EP_BIT     = 14;
  localparam int TC_LSB     = 20;
  localparam int TYPE_LSB   = 24;
  localparam int FMT_LSB    = 29;
  localparam int BC_LSB     = 32;
  localparam int STATUS_LSB = 45;
  localparam int CPLID_LSB  = 48;
  localparam int LADDR_LSB  = 64;
  localparam int TAG_LSB    = 72;
  localparam int REQID_LSB  = 80;

  localparam logic [4:0] TYPE_CPL   = 5'b01010;
  localparam logic [4:0] TYPE_CPLLK = 5'b01011;

  // CC descriptor offsets within the 96-bit descriptor
  localparam int CC_LADDR_LSB    = 0;
  localparam int CC_BC_LSB       = 16;
  localparam int CC_LOCKED_BIT   = 29;
  localparam int CC_DWC_LSB      = 32;
  localparam int CC_STATUS_LSB   = 43;
  localparam int CC_EP_BIT       = 46;
  localparam int CC_REQID_LSB    = 48;
  localparam int CC_TAG_LSB      = 64;
  localparam int CC_CPLID_LSB    = 72;
  localparam int CC_CPLID_EN_BIT = 88;
  localparam int CC_TC_LSB       = 89;
  localparam int CC_ATTR_LSB     = 92;

  localparam logic [10:0] MAX_DW = 11'd1024;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } cc_state_e;

  function automatic logic [3:0] keep_dw(input logic [15:0] k);
    return {k[12], k[8], k[4], k[0]};
  endfunction

  function automatic logic [2:0] dw_count(input logic [3:0] kd);
    return 3'(kd[0]) + 3'(kd[1]) + 3'(kd[2]) + 3'(kd[3]);
  endfunction

endpackage

// File: rtl/s_axis_cc_adapt_x4_skid.sv
// Output register with a one-entry skid buffer; in_ready never looks at out_ready.
// valid/ready: a word moves when valid && ready on the same rising edge; data holds while valid && !ready.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;

  assign in_ready = !skid_full;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_full <= 1'b0;
      skid_data <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!out_valid || out_ready) begin
      // Skid entry is older than anything arriving now, so it goes out first
      if (skid_full) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_full <= 1'b1;
      skid_data <= in_data;
    end
  end

endmodule

// File: rtl/s_axis_cc_adapt_x4.sv
// LitePCIe legacy completion TLPs -> UltraScale+ x4 CC AXI-Stream: header remap,
// byte->dword keep, payload length check, non-completion drop.
module s_axis_cc_adapt_x4
  import pcie_cc_adapt_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_cc_tkeep,
  input  logic                  s_axis_cc_tlast,
  input  logic [3:0]            s_axis_cc_tuser,
  input  logic                  s_axis_cc_tvalid,
  output logic                  s_axis_cc_tready,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata_a,
  output logic [3:0]            s_axis_cc_tkeep_a,
  output logic                  s_axis_cc_tlast_a,
  output logic [32:0]           s_axis_cc_tuser_a,
  output logic                  s_axis_cc_tvalid_a,
  input  logic [3:0]            s_axis_cc_tready_a,
  output logic                  cpl_drop,
  output cc_state_e             cc_state_dbg
);

  localparam int SKID_W = DATA_WIDTH + 4 + 1 + 1;

  cc_state_e             state;
  logic                  rdy_en, skid_ready, in_fire, is_cpl, hdr_fmt1, fwd_valid, disc;
  logic                  err_q, err_base, out_disc;
  logic [4:0]            hdr_type;
  logic [9:0]            hdr_len;
  logic [11:0]           hdr_bc;
  logic [10:0]           hdr_dwc, cnt_q, exp_dw_q, cnt_base, cnt_sum, cnt_next, exp_dw;
  logic [2:0]            beat_dw;
  logic [3:0]            keep_a;
  logic [95:0]           desc;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  unused_ok;

  assign s_axis_cc_tready = rdy_en && skid_ready;
  assign in_fire          = s_axis_cc_tvalid && s_axis_cc_tready;
  assign cc_state_dbg     = state;
  assign unused_ok        = &{1'b0, s_axis_cc_tuser[3:1], s_axis_cc_tready_a[3:1],
                              s_axis_cc_tkeep[15:13], s_axis_cc_tkeep[11:9],
                              s_axis_cc_tkeep[7:5], s_axis_cc_tkeep[3:1]};

  always_comb begin
    hdr_type = s_axis_cc_tdata[TYPE_LSB +: 5];
    hdr_fmt1 = s_axis_cc_tdata[FMT_LSB + 1];
    hdr_len  = s_axis_cc_tdata[LEN_LSB +: 10];
    hdr_bc   = s_axis_cc_tdata[BC_LSB +: 12];
    is_cpl   = (hdr_type[4:1] == TYPE_CPL[4:1]);
    hdr_dwc  = (hdr_len == 10'd0) ? MAX_DW : {1'b0, hdr_len};

    desc = '0;
    desc[CC_LADDR_LSB +: 7]  = s_axis_cc_tdata[LADDR_LSB +: 7];
    desc[CC_BC_LSB +: 13]    = (hdr_bc == 12'd0) ? 13'h1000 : {1'b0, hdr_bc};
    desc[CC_LOCKED_BIT]      = (hdr_type == TYPE_CPLLK);
    desc[CC_DWC_LSB +: 11]   = hdr_dwc;
    desc[CC_STATUS_LSB +: 3] = s_axis_cc_tdata[STATUS_LSB +: 3];
    desc[CC_EP_BIT]          = s_axis_cc_tdata[EP_BIT];
    desc[CC_REQID_LSB +: 16] = s_axis_cc_tdata[REQID_LSB +: 16];
    desc[CC_TAG_LSB +: 8]    = s_axis_cc_tdata[TAG_LSB +: 8];
    desc[CC_CPLID_LSB +: 16] = s_axis_cc_tdata[CPLID_LSB +: 16];
    desc[CC_CPLID_EN_BIT]    = 1'b1;
    desc[CC_TC_LSB +: 3]     = s_axis_cc_tdata[TC_LSB +: 3];
    desc[CC_ATTR_LSB +: 2]   = s_axis_cc_tdata[ATTR_LSB +: 2];

    if (state == HDR) begin
      // Only DW3 of the header beat can be payload, and only for data completions
      beat_dw  = hdr_fmt1 ? {2'b0, s_axis_cc_tkeep[12]} : 3'd0;
      cnt_base = '0;
      exp_dw   = hdr_fmt1 ? hdr_dwc : '0;
      err_base = 1'b0;
      data_a   = {s_axis_cc_tdata[DATA_WIDTH-1:96], desc};
      keep_a   = hdr_fmt1 ? {s_axis_cc_tkeep[12], 3'b111} : 4'b0111;
    end else begin
      beat_dw  = dw_count(keep_dw(s_axis_cc_tkeep));
      cnt_base = cnt_q;
      exp_dw   = exp_dw_q;
      err_base = err_q;
      data_a   = s_axis_cc_tdata;
      keep_a   = keep_dw(s_axis_cc_tkeep);
    end

    cnt_sum   = cnt_base + {8'b0, beat_dw};
    cnt_next  = (cnt_sum > MAX_DW) ? MAX_DW : cnt_sum;
    disc      = s_axis_cc_tlast && (err_base || s_axis_cc_tuser[0] || (cnt_next != exp_dw));
    fwd_valid = in_fire && ((state == BODY) || ((state == HDR) && is_cpl));
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state    <= HDR;
      rdy_en   <= 1'b0;
      cpl_drop <= 1'b0;
      cnt_q    <= '0;
      exp_dw_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      cpl_drop <= 1'b0;
      if (in_fire) begin
        case (state)
          HDR: begin
            cnt_q    <= s_axis_cc_tlast ? '0 : cnt_next;
            exp_dw_q <= exp_dw;
            err_q    <= s_axis_cc_tuser[0];
            if (!is_cpl) begin
              cpl_drop <= 1'b1;
              state    <= s_axis_cc_tlast ? HDR : DROP;
            end else begin
              state    <= s_axis_cc_tlast ? HDR : BODY;
            end
          end
          BODY: begin
            cnt_q <= s_axis_cc_tlast ? '0 : cnt_next;
            err_q <= err_q || s_axis_cc_tuser[0];
            if (s_axis_cc_tlast) state <= HDR;
          end
          default: begin
            if (s_axis_cc_tlast) state <= HDR;
          end
        endcase
      end
    end
  end

  axis_skid_reg #(.WIDTH(SKID_W)) u_skid (
    .clk       (user_clk),
    .rst       (user_reset),
    .in_data   ({data_a, keep_a, s_axis_cc_tlast, disc}),
    .in_valid  (fwd_valid),
    .in_ready  (skid_ready),
    .out_data  ({s_axis_cc_tdata_a, s_axis_cc_tkeep_a, s_axis_cc_tlast_a, out_disc}),
    .out_valid (s_axis_cc_tvalid_a),
    .out_ready (s_axis_cc_tready_a[0])
  );

  assign s_axis_cc_tuser_a = {32'b0, out_disc};

endmodule
